// File: rtl/core_pkg.sv
// Shared fetch-side definitions: FSM state encoding and instruction constants.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: JALR > JAL > taken branch > sequential.
module next_pc_calc
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic signed [31:0] imm_s;
    logic signed [31:0] pc_rel;
    logic signed [31:0] reg_rel;

    // Immediate arrives sign-extended; 32-bit sums wrap silently.
    assign imm_s   = $signed(imm);
    assign pc_rel  = $signed(pc) + imm_s;
    assign reg_rel = $signed(rs1) + imm_s;

    always_comb begin
        next_pc = pc + INSTR_BYTES;
        if (jump_reg) begin
            next_pc = $unsigned(reg_rel) & ~32'h1;
        end else if (jump || branch_taken) begin
            next_pc = $unsigned(pc_rel);
        end
        misaligned = is_misaligned(next_pc);
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Owns the architectural PC: fetches one word per instruction, holds it for
// decode until execute advances, then steps to the computed next PC.
module instruction_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic        Advance,
    input  logic        BranchTaken,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] Immediate,
    input  logic [31:0] Rs1Data,
    output logic        MisalignFault,
    output logic [31:0] RetireCount
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         fault_q;
    logic [31:0]  retire_q;
    logic [31:0]  next_pc;
    logic         misaligned;
    logic         fetch_done;
    logic         advance_en;

    next_pc_calc u_next_pc (
        .pc           (pc_q),
        .imm          (Immediate),
        .rs1          (Rs1Data),
        .branch_taken (BranchTaken),
        .jump         (Jump),
        .jump_reg     (JumpReg),
        .next_pc      (next_pc),
        .misaligned   (misaligned)
    );

    // Handshake inputs only matter in the state that expects them.
    assign fetch_done = (state_q == FETCH) && IMemReady;
    assign advance_en = (state_q == VALID) && Advance;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (IMemReady) state_d = VALID;
            VALID:   if (Advance)   state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            fault_q  <= 1'b0;
            retire_q <= 32'd0;
        end else begin
            state_q <= state_d;
            fault_q <= 1'b0;
            if (fetch_done) begin
                instr_q <= IMemData;
            end
            // A misaligned target still retires the current instruction.
            if (advance_en) begin
                pc_q     <= misaligned ? TRAP_PC : next_pc;
                retire_q <= retire_q + 32'd1;
                fault_q  <= misaligned;
            end
        end
    end

    // Request/valid decode from registered state only.
    assign IMemReq       = (state_q == FETCH);
    assign InstrValid    = (state_q == VALID);
    assign IMemAddr      = pc_q;
    assign PC            = pc_q;
    assign PCPlus4       = pc_q + INSTR_BYTES;
    assign Instruction   = instr_q;
    assign MisalignFault = fault_q;
    assign RetireCount   = retire_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench for instruction_fetch_unit: directed control-flow vectors.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic [31:0] IMemData;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Advance;
    logic        BranchTaken;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] Immediate;
    logic [31:0] Rs1Data;
    logic        MisalignFault;
    logic [31:0] RetireCount;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] retire;
    } fetch_exp_t;

    fetch_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .IMemReq       (IMemReq),
        .IMemAddr      (IMemAddr),
        .IMemReady     (IMemReady),
        .IMemData      (IMemData),
        .Instruction   (Instruction),
        .InstrValid    (InstrValid),
        .PC            (PC),
        .PCPlus4       (PCPlus4),
        .Advance       (Advance),
        .BranchTaken   (BranchTaken),
        .Jump          (Jump),
        .JumpReg       (JumpReg),
        .Immediate     (Immediate),
        .Rs1Data       (Rs1Data),
        .MisalignFault (MisalignFault),
        .RetireCount   (RetireCount)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_0013;
    endfunction

    assign IMemData = mem_word(IMemAddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every completed fetch must match the next expected transaction.
    always @(negedge clk) begin
        if (!reset && IMemReq && IMemReady) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fetch_unexpected: got addr %h expected none", IMemAddr);
            end else begin
                fetch_exp_t e;
                e = exp_q.pop_front();
                if (IMemAddr !== e.addr || RetireCount !== e.retire) begin
                    errors++;
                    $display("FAIL fetch: got addr %h retire %0d expected addr %h retire %0d",
                             IMemAddr, RetireCount, e.addr, e.retire);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input logic [31:0] pc_exp);
        int n;
        n = 0;
        while (!InstrValid && n < 20) begin
            step();
            n++;
        end
        check("valid_timeout", {31'd0, InstrValid}, 32'd1);
        check("pc", PC, pc_exp);
        check("instr", Instruction, mem_word(pc_exp));
    endtask

    // Issue Advance with the given selects and queue the fetch it should cause.
    task automatic advance(input logic br, input logic j, input logic jr,
                           input logic [31:0] imm, input logic [31:0] rs1,
                           input logic [31:0] exp_addr, input logic [31:0] exp_ret,
                           input logic push);
        fetch_exp_t e;
        e.addr   = exp_addr;
        e.retire = exp_ret;
        if (push) exp_q.push_back(e);
        Advance = 1'b1; BranchTaken = br; Jump = j; JumpReg = jr;
        Immediate = imm; Rs1Data = rs1;
        step();
        Advance = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
        Immediate = 32'hDEAD_BEEF; Rs1Data = 32'hDEAD_BEEF;
    endtask

    initial begin
        fetch_exp_t e;
        reset = 1'b1; IMemReady = 1'b1; Advance = 1'b0;
        BranchTaken = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
        Immediate = 32'd0; Rs1Data = 32'd0;
        step(); step();
        check("rst_req", {31'd0, IMemReq}, 32'd0);
        check("rst_valid", {31'd0, InstrValid}, 32'd0);
        check("rst_instr", Instruction, 32'h0000_0013);
        check("rst_pc", PC, 32'h0);
        check("rst_retire", RetireCount, 32'd0);
        check("rst_fault", {31'd0, MisalignFault}, 32'd0);

        // Cycle 1 IDLE, cycle 2 request at 0, cycle 3 valid.
        e.addr = 32'h0; e.retire = 32'd0;
        exp_q.push_back(e);
        reset = 1'b0;
        check("idle_req", {31'd0, IMemReq}, 32'd0);
        step();
        check("first_req", {31'd0, IMemReq}, 32'd1);
        check("first_addr", IMemAddr, 32'h0);
        step();
        check("first_valid", {31'd0, InstrValid}, 32'd1);
        check("first_instr", Instruction, mem_word(32'h0));
        check("pcplus4", PCPlus4, 32'h4);

        advance(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h40, 32'd1, 1'b1);
        wait_valid(32'h40);
        // Sequential with stray immediate: selects are clear so imm is unused.
        advance(1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h44, 32'd2, 1'b1);
        wait_valid(32'h44);
        advance(1'b0, 1'b1, 1'b0, 32'hBC, 32'h0, 32'h100, 32'd3, 1'b1);
        wait_valid(32'h100);
        advance(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'hF0, 32'd4, 1'b1);
        wait_valid(32'hF0);
        advance(1'b1, 1'b1, 1'b1, 32'h4, 32'h2001, 32'h2004, 32'd5, 1'b1);
        wait_valid(32'h2004);
        advance(1'b0, 1'b1, 1'b0, 32'hFFFF_E00C, 32'h0, 32'h10, 32'd6, 1'b1);
        wait_valid(32'h10);
        check("no_fault_yet", {31'd0, MisalignFault}, 32'd0);

        // JAL to 0x12 traps.
        advance(1'b0, 1'b1, 1'b0, 32'h2, 32'h0, 32'h100, 32'd7, 1'b1);
        check("fault_pulse", {31'd0, MisalignFault}, 32'd1);
        step();
        check("fault_clear", {31'd0, MisalignFault}, 32'd0);
        wait_valid(32'h100);

        // Reach the top of the address space, then wrap sequentially.
        advance(1'b0, 1'b1, 1'b0, 32'hFFFF_FEFC, 32'h0, 32'hFFFF_FFFC, 32'd8, 1'b1);
        wait_valid(32'hFFFF_FFFC);
        check("pcplus4_wrap", PCPlus4, 32'h0);
        advance(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'd9, 1'b1);
        wait_valid(32'h0);

        // Stall: memory withholds ready while the request sits at 4.
        IMemReady = 1'b0;
        advance(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 32'd10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req", {31'd0, IMemReq}, 32'd1);
            check("stall_addr", IMemAddr, 32'h4);
        end
        reset = 1'b1;
        step();
        check("abort_req", {31'd0, IMemReq}, 32'd0);
        check("abort_valid", {31'd0, InstrValid}, 32'd0);
        reset = 1'b0;
        IMemReady = 1'b1;
        step();
        IMemReady = 1'b0;
        check("idle_ready_instr", Instruction, 32'h0000_0013);
        check("idle_ready_valid", {31'd0, InstrValid}, 32'd0);
        check("post_rst_pc", PC, 32'h0);
        check("post_rst_retire", RetireCount, 32'd0);
        step(); step();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
